// File: rtl/inst_fetch_q.sv
// inst_fetch_q: single-outstanding instruction fetcher feeding a DEPTH-entry {pc,inst} queue.
// A redirect flushes the queue, and any in-flight response is marked for discard.
module inst_fetch_q #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] fpc, fpc_nx, req_addr, req_addr_nx;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic        push, pop;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx    = state;
    fpc_nx      = fpc;
    req_addr_nx = req_addr;
    push        = 1'b0;
    case (state)
      IDLE: if (!redirect_valid && count < FULL) begin
        state_nx    = WAIT;
        req_addr_nx = fpc;
      end
      WAIT: if (imem_ack) begin
        state_nx = IDLE;
        push     = !redirect_valid;
        fpc_nx   = req_addr + 32'd4;
      end else if (redirect_valid) state_nx = DROP;
      DROP: if (imem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // redirect outranks the sequential increment
    if (redirect_valid) fpc_nx = {redirect_pc[31:2], 2'b00};
  end

  assign pop       = out_valid && out_ready && !redirect_valid;
  assign imem_req  = state != IDLE;
  assign imem_addr = req_addr;
  assign out_valid = count != '0;
  assign out_pc    = pc_q[rptr];
  assign out_inst  = inst_q[rptr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      fpc      <= fpc_nx;
      req_addr <= req_addr_nx;
      if (redirect_valid) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc_q[wptr]   <= req_addr;
          inst_q[wptr] <= imem_rdata;
          wptr         <= wptr + AW'(1);
        end
        if (pop) rptr <= rptr + AW'(1);
        count <= push && !pop ? count + (AW+1)'(1) :
                 !push && pop ? count - (AW+1)'(1) : count;
      end
    end
endmodule
